regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between the CPU writeback stage and the game-side I/O logic. The I/O logic posts register writes, such as a new block ID for r29, through a valid/ready handshake into a small FIFO. The CPU always has priority, and starvation of the I/O side is bounded by a one-cycle CPU stall. The block sits between the writeback stage, the game input logic and the register file write inputs.

---
 rtl/regfile_write_arbiter.sv | 96 +++++++++
 tb/tb_regfile_write_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the CPU writeback stage
// (priority) and a small FIFO of I/O-posted writes, with a bounded-starvation CPU stall.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     cpu_we,
  input  logic [4:0]               cpu_rd,
  input  logic [31:0]              cpu_data,
  input  logic                     io_valid,
  input  logic [4:0]               io_rd,
  input  logic [31:0]              io_data,
  output logic                     io_ready,
  output logic                     cpu_stall,
  output logic                     ctrl_writeEnable,
  output logic [4:0]               ctrl_writeReg,
  output logic [31:0]              data_writeReg,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL        = CW'(DEPTH);
  localparam logic [7:0]    STARVE_LAST = 8'(STARVE_LIMIT - 1);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    starve;

  logic not_empty;
  logic accept;
  logic push;
  logic cpu_win;
  logic fifo_win;
  logic starve_hit;

  assign not_empty  = (count != '0);
  assign io_ready   = ~ctrl_reset & (count != FULL);
  assign accept     = io_valid & io_ready;
  // Writes to r0 complete the handshake but never occupy a slot.
  assign push       = accept & (io_rd != 5'd0);
  assign cpu_win    = cpu_we & ~cpu_stall;
  assign fifo_win   = ~cpu_win & not_empty;
  assign starve_hit = not_empty & cpu_win & (starve == STARVE_LAST);
  assign fifo_count = count;

  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    if (cpu_win) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = cpu_rd;
      data_writeReg    = cpu_data;
    end else if (fifo_win) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = rd_mem[rd_ptr];
      data_writeReg    = data_mem[rd_ptr];
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      starve    <= 8'd0;
      cpu_stall <= 1'b0;
    end else begin
      if (fifo_win) rd_ptr <= rd_ptr + PW'(1);
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      unique case ({push, fifo_win})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // The stall is a one-cycle pulse; the cycle it covers always drains the head.
      if (!not_empty || fifo_win || starve_hit) starve <= 8'd0;
      else if (cpu_win)                         starve <= starve + 8'd1;
      cpu_stall <= starve_hit;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      rd_mem[wr_ptr]   <= io_rd;
      data_mem[wr_ptr] <= io_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 4;
  localparam int SL    = 8;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        cpu_we = 1'b0;
  logic [4:0]  cpu_rd = 5'd0;
  logic [31:0] cpu_data = 32'd0;
  logic        io_valid = 1'b0;
  logic [4:0]  io_rd = 5'd0;
  logic [31:0] io_data = 32'd0;
  logic        io_ready;
  logic        cpu_stall;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [2:0]  fifo_count;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_data(cpu_data),
    .io_valid(io_valid), .io_rd(io_rd), .io_data(io_data),
    .io_ready(io_ready), .cpu_stall(cpu_stall),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .fifo_count(fifo_count)
  );

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 0;
  int   cyc_n = 0;
  ent_t mq[$];
  int   m_starve = 0;
  bit   m_stall = 0;
  logic [4:0] wlog[$];
  int   stall_cyc[$];

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: pending I/O writes as a queue; the CPU wins unless stalled.
  always @(posedge ctrl_reset) begin
    mq.delete();
    m_starve = 0;
    m_stall  = 0;
  end

  always @(posedge clock) begin
    bit cw, fw, acc, nxt;
    int n;
    cyc_n++;
    if (ctrl_reset) begin
      mq.delete();
      m_starve = 0;
      m_stall  = 0;
    end else begin
      n   = mq.size();
      cw  = cpu_we && !m_stall;
      fw  = !cw && (n > 0);
      acc = io_valid && (n != DEPTH);
      nxt = 0;
      if (n == 0 || fw) m_starve = 0;
      else if (m_starve == SL - 1) begin
        m_starve = 0;
        nxt = 1;
      end else m_starve++;
      m_stall = nxt;
      if (fw) void'(mq.pop_front());
      if (acc && io_rd != 5'd0) mq.push_back('{io_rd, io_data});
    end
  end

  always @(negedge clock) begin
    bit cw, fw;
    logic [4:0]  ereg;
    logic [31:0] edata;
    if (chk_en) begin
      cw = cpu_we && !m_stall;
      fw = !cw && (mq.size() > 0);
      ereg  = cw ? cpu_rd   : (fw ? mq[0].rd   : 5'd0);
      edata = cw ? cpu_data : (fw ? mq[0].data : 32'd0);
      chk("io_ready",   io_ready,   !ctrl_reset && (mq.size() != DEPTH));
      chk("cpu_stall",  cpu_stall,  m_stall);
      chk("fifo_count", fifo_count, mq.size());
      chk("write_en",   ctrl_writeEnable, cw || fw);
      chk("write_reg",  ctrl_writeReg,  ereg);
      chk("write_data", data_writeReg,  edata);
      if (ctrl_writeEnable && !(cpu_we && !cpu_stall)) wlog.push_back(ctrl_writeReg);
      if (cpu_stall) stall_cyc.push_back(cyc_n);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1;
    chk_en = 1;
    ctrl_reset = 1'b1;
    @(negedge clock);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", io_ready, 0);
    chk("rst_we", ctrl_writeEnable, 0);
    tick();
    ctrl_reset = 1'b0;

    // Single I/O write with an idle CPU.
    io_valid = 1; io_rd = 5'd29; io_data = 32'h0000_0007;
    @(negedge clock);
    chk("t1_ready", io_ready, 1);
    chk("t1_count0", fifo_count, 0);
    tick();
    io_valid = 0;
    @(negedge clock);
    chk("t1_we", ctrl_writeEnable, 1);
    chk("t1_reg", ctrl_writeReg, 29);
    chk("t1_data", data_writeReg, 32'h7);
    chk("t1_count1", fifo_count, 1);
    tick();
    @(negedge clock);
    chk("t1_count_end", fifo_count, 0);
    chk("t1_we_end", ctrl_writeEnable, 0);

    // Continuous CPU writes starve the FIFO; stall pulses drain r1..r4.
    tick();
    cpu_we = 1; cpu_rd = 5'd5; cpu_data = 32'hA5A5_A5A5;
    wlog.delete(); stall_cyc.delete();
    for (int i = 1; i <= 4; i++) begin
      io_valid = 1; io_rd = 5'(i); io_data = 32'(100 + i);
      tick();
    end
    io_valid = 0;
    repeat (40) tick();
    chk("t2_stalls", stall_cyc.size(), 4);
    for (int i = 0; i + 1 < stall_cyc.size(); i++)
      chk("t2_stall_gap", stall_cyc[i+1] - stall_cyc[i], SL + 1);
    chk("t2_writes", wlog.size(), 4);
    for (int i = 0; i < wlog.size(); i++) chk("t2_order", wlog[i], i + 1);
    chk("t2_count_end", fifo_count, 0);

    // Full FIFO: a pop in the same cycle does not open io_ready.
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      io_valid = 1; io_rd = 5'(10 + i); io_data = 32'(200 + i);
      tick();
    end
    cpu_we = 0; io_valid = 1; io_rd = 5'd6; io_data = 32'h66;
    @(negedge clock);
    chk("t3_ready_full", io_ready, 0);
    chk("t3_pop_we", ctrl_writeEnable, 1);
    chk("t3_pop_reg", ctrl_writeReg, 10);
    chk("t3_count_full", fifo_count, 4);
    tick();
    @(negedge clock);
    chk("t3_ready_after", io_ready, 1);
    chk("t3_count3", fifo_count, 3);
    tick();
    io_valid = 0;
    @(negedge clock);
    chk("t3_count_pushpop", fifo_count, 3);
    chk("t3_reg12", ctrl_writeReg, 12);
    repeat (6) tick();
    chk("t3_writes", wlog.size(), 5);
    if (wlog.size() == 5) chk("t3_last", wlog[4], 6);

    // Write to r0 is accepted but dropped.
    io_valid = 1; io_rd = 5'd0; io_data = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("t4_ready", io_ready, 1);
    chk("t4_we", ctrl_writeEnable, 0);
    tick();
    io_valid = 0;
    @(negedge clock);
    chk("t4_count", fifo_count, 0);
    chk("t4_we_after", ctrl_writeEnable, 0);

    // Reset mid-drain discards pending entries.
    tick();
    cpu_we = 1; cpu_rd = 5'd7; cpu_data = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      io_valid = 1; io_rd = 5'(20 + i); io_data = 32'(300 + i);
      tick();
    end
    io_valid = 0; cpu_we = 0;
    @(negedge clock);
    chk("t5_drain_reg", ctrl_writeReg, 20);
    tick();
    ctrl_reset = 1;
    #1;
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_ready", io_ready, 0);
    chk("t5_rst_we", ctrl_writeEnable, 0);
    tick();
    ctrl_reset = 0;
    wlog.delete();
    repeat (5) tick();
    chk("t5_no_stale", wlog.size(), 0);

    // Alternating CPU writes leave room to drain without a stall.
    cpu_we = 1;
    for (int i = 0; i < 2; i++) begin
      io_valid = 1; io_rd = 5'(24 + i); io_data = 32'(400 + i);
      tick();
    end
    io_valid = 0;
    wlog.delete(); stall_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      cpu_we = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    chk("t6_stalls", stall_cyc.size(), 0);
    chk("t6_writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t6_first", wlog[0], 24);
      chk("t6_second", wlog[1], 25);
    end
    chk("t6_count", fifo_count, 0);

    cpu_we = 0;
    @(negedge clock);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
